// File: rtl/mux_scan_pkg.sv
// Shared constants and FSM state type for the mux scan sequencer.
package mux_scan_pkg;

  localparam int SEL_W = 3;
  localparam int N_CH  = 1 << SEL_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Control, mux-select and word-output signals of the scan sequencer.
// The master side is the sequencer; the slave side is the environment
// (mux plus word consumer plus controller).
interface mux_scan_sequencer_if
  import mux_scan_pkg::*;
();

  logic             start;
  logic             cont;
  logic             clr_ovr;
  logic [SEL_W-1:0] sel;
  logic             mux_out;
  logic [N_CH-1:0]  word_data;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             overrun;

  modport master (
    input  start, cont, clr_ovr, mux_out, word_ready,
    output sel, word_data, word_valid, busy, overrun
  );

  modport slave (
    output start, cont, clr_ovr, mux_out, word_ready,
    input  sel, word_data, word_valid, busy, overrun
  );

endinterface

// File: rtl/scan_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle.
module scan_dwell_counter #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CNT_W = 5;

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_W'(DWELL - 1));

  // Count up while enabled, wrapping to zero on the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an external 8:1 mux select through all channels, holding each for
// DWELL cycles, samples the mux output once per channel and presents the
// packed byte on a valid/ready output with overrun detection.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_scan_sequencer_if.master  bus
);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] ch;
  logic [N_CH-1:0]  shadow;
  logic             tc;
  logic             cap;
  logic             last;
  logic             accept;
  logic             load;
  logic             valid_nxt;

  // A channel sample is taken on the final dwell cycle; the last channel
  // completes the word, which loads if the output register is or becomes free.
  assign accept    = bus.word_valid && bus.word_ready;
  assign cap       = (state == SCAN) && tc;
  assign last      = cap && (ch == SEL_W'(N_CH - 1));
  assign load      = last && (!bus.word_valid || bus.word_ready);
  assign valid_nxt = load || (bus.word_valid && !accept);

  scan_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == SCAN),
    .clr   (state != SCAN),
    .tc    (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    bus.sel   = '0;
    bus.busy  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = SCAN;
      end
      SCAN: begin
        bus.sel  = ch;
        bus.busy = 1'b1;
        if (last) begin
          if (bus.cont)     state_nxt = SCAN;
          else if (valid_nxt) state_nxt = WAIT_ACK;
          else              state_nxt = IDLE;
        end
      end
      WAIT_ACK: begin
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel counter and per-channel sample capture; channel wraps 7 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch     <= '0;
      shadow <= '0;
    end else if (state == IDLE) begin
      ch <= '0;
    end else if (cap) begin
      shadow[ch] <= bus.mux_out;
      ch         <= ch + SEL_W'(1);
    end
  end

  // Output word register with valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.word_data  <= '0;
      bus.word_valid <= 1'b0;
    end else if (load) begin
      bus.word_data  <= {bus.mux_out, shadow[N_CH-2:0]};
      bus.word_valid <= 1'b1;
    end else if (accept) begin
      bus.word_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new drop takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            bus.overrun <= 1'b0;
    else if (last && !load) bus.overrun <= 1'b1;
    else if (bus.clr_ovr)  bus.overrun <= 1'b0;
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer; the 8:1 mux is modelled by an
// indexed select of a data byte, closing the loop between sel and mux_out.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data1;
  logic [7:0] data2;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] e1;
  logic [7:0] e2;

  always #5 clk = ~clk;

  mux_scan_sequencer_if bus1 ();
  mux_scan_sequencer_if bus2 ();

  assign bus1.mux_out = data1[bus1.sel];
  assign bus2.mux_out = data2[bus2.sel];

  mux_scan_sequencer #(.DWELL(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux_scan_sequencer #(.DWELL(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for DWELL=2 instance: compare every accepted word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus1.word_valid === 1'b1 && bus1.word_ready === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL word1_unexpected: got %0h expected none", bus1.word_data);
      end else begin
        e1 = q1.pop_front();
        if (bus1.word_data !== e1) begin
          errors++;
          $display("FAIL word1: got %0h expected %0h at %0t", bus1.word_data, e1, $time);
        end
      end
    end
  end

  // Monitor for DWELL=1 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus2.word_valid === 1'b1 && bus2.word_ready === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL word2_unexpected: got %0h expected none", bus2.word_data);
      end else begin
        e2 = q2.pop_front();
        if (bus2.word_data !== e2) begin
          errors++;
          $display("FAIL word2: got %0h expected %0h at %0t", bus2.word_data, e2, $time);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus1.start = 0; bus1.cont = 0; bus1.clr_ovr = 0; bus1.word_ready = 0;
    bus2.start = 0; bus2.cont = 0; bus2.clr_ovr = 0; bus2.word_ready = 0;
    data1 = 8'h00; data2 = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    check("rst_sel",     bus1.sel, 0);
    check("rst_data",    bus1.word_data, 0);
    check("rst_valid",   bus1.word_valid, 0);
    check("rst_busy",    bus1.busy, 0);
    check("rst_overrun", bus1.overrun, 0);
    check("rst2_valid",  bus2.word_valid, 0);

    // 1: single scan of A5
    data1 = 8'hA5; bus1.word_ready = 1; q1.push_back(8'hA5);
    bus1.start = 1; tick(1); bus1.start = 0;
    for (int c = 0; c < 16; c++) begin
      check("t1_sel", bus1.sel, c / 2);
      check("t1_busy", bus1.busy, 1);
      if (c == 15) check("t1_valid_early", bus1.word_valid, 0);
      tick(1);
    end
    check("t1_valid", bus1.word_valid, 1);
    check("t1_data", bus1.word_data, 8'hA5);
    tick(1);
    check("t1_idle_busy", bus1.busy, 0);
    check("t1_idle_valid", bus1.word_valid, 0);
    check("t1_idle_sel", bus1.sel, 0);

    // 2: continuous back-to-back 3C then C3
    data1 = 8'h3C; bus1.cont = 1; q1.push_back(8'h3C); q1.push_back(8'hC3);
    bus1.start = 1; tick(1); bus1.start = 0;
    tick(15);
    check("t2_sel7", bus1.sel, 7);
    tick(1);
    check("t2_wrap_sel", bus1.sel, 0);
    check("t2_wrap_busy", bus1.busy, 1);
    check("t2_valid1", bus1.word_valid, 1);
    data1 = 8'hC3; bus1.cont = 0;
    tick(16);
    check("t2_valid2", bus1.word_valid, 1);
    check("t2_overrun", bus1.overrun, 0);
    tick(1);
    check("t2_idle", bus1.busy, 0);

    // 3: ready low for two scans -> overrun, word held
    bus1.word_ready = 0; bus1.cont = 1; data1 = 8'h5A; q1.push_back(8'h5A);
    bus1.start = 1; tick(1); bus1.start = 0;
    tick(16);
    check("t3_valid", bus1.word_valid, 1);
    check("t3_data1", bus1.word_data, 8'h5A);
    check("t3_ovr_early", bus1.overrun, 0);
    data1 = 8'h0F; bus1.cont = 0;
    tick(15);
    check("t3_ovr_pre", bus1.overrun, 0);
    tick(1);
    check("t3_overrun", bus1.overrun, 1);
    check("t3_held", bus1.word_data, 8'h5A);
    check("t3_waitack_busy", bus1.busy, 0);
    bus1.clr_ovr = 1; tick(1); bus1.clr_ovr = 0;
    check("t3_clr", bus1.overrun, 0);
    check("t3_still_valid", bus1.word_valid, 1);
    bus1.word_ready = 1; tick(1);
    check("t3_acked", bus1.word_valid, 0);
    bus1.word_ready = 0;

    // 4: ready rises exactly when the next word completes
    bus1.cont = 1; data1 = 8'h11; q1.push_back(8'h11); q1.push_back(8'h22);
    bus1.start = 1; tick(1); bus1.start = 0;
    tick(16);
    check("t4_valid1", bus1.word_valid, 1);
    data1 = 8'h22; bus1.cont = 0;
    tick(15);
    bus1.word_ready = 1;
    tick(1);
    check("t4_valid_kept", bus1.word_valid, 1);
    check("t4_new_data", bus1.word_data, 8'h22);
    check("t4_no_overrun", bus1.overrun, 0);
    tick(1);
    check("t4_drained", bus1.word_valid, 0);
    check("t4_idle", bus1.busy, 0);

    // 5: asynchronous reset mid-scan at sel=4
    data1 = 8'h99;
    bus1.start = 1; tick(1); bus1.start = 0;
    tick(8);
    check("t5_sel4", bus1.sel, 4);
    #2 rst_n = 0;
    #1;
    check("t5_rst_sel", bus1.sel, 0);
    check("t5_rst_busy", bus1.busy, 0);
    check("t5_rst_valid", bus1.word_valid, 0);
    check("t5_rst_data", bus1.word_data, 0);
    @(posedge clk); #1 rst_n = 1;
    tick(1);
    data1 = 8'h6B; q1.push_back(8'h6B);
    bus1.start = 1; tick(1); bus1.start = 0;
    tick(16);
    check("t5_valid", bus1.word_valid, 1);
    check("t5_data", bus1.word_data, 8'h6B);
    tick(1);

    // 6: DWELL=1, extra start while busy ignored
    data2 = 8'hFF; bus2.word_ready = 1; q2.push_back(8'hFF);
    bus2.start = 1; tick(1); bus2.start = 0;
    tick(1);
    check("t6_sel1", bus2.sel, 1);
    bus2.start = 1; tick(1); bus2.start = 0;
    tick(5);
    check("t6_valid_early", bus2.word_valid, 0);
    tick(1);
    check("t6_valid", bus2.word_valid, 1);
    check("t6_data", bus2.word_data, 8'hFF);
    tick(1);
    check("t6_idle", bus2.busy, 0);
    tick(1);
    check("t6_no_restart", bus2.busy, 0);

    // Drain scoreboards with a bounded wait
    for (int i = 0; i < 40 && (q1.size() + q2.size()) != 0; i++) tick(1);
    check("drain", q1.size() + q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
